// File: rtl/intc_pkg.sv
// Shared register offsets, FSM encoding and source count for the interrupt controller.
package intc_pkg;

  localparam int NSRC = 4;

  localparam logic [2:0] OFF_ENABLE  = 3'd0;
  localparam logic [2:0] OFF_PENDING = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_RSVD    = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intc_edge_detect.sv
// Per-bit rising-edge detector: input is registered once, rise_o flags 0->1 between the last two samples.
// Latency: one edge to sample, rise_o valid the cycle after; no backpressure.
module intc_edge_detect #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] sig_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] samp_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      samp_q <= '0;
      prev_q <= '0;
    end else begin
      samp_q <= sig_i;
      prev_q <= samp_q;
    end
  end

  assign rise_o = samp_q & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped, non-nesting, fixed-priority interrupt controller for four edge-triggered sources.
// Latency: source edge to int_req is three edges; no backpressure, the CPU releases service with int_ret.
module interrupt_controller import intc_pkg::*; #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NSRC      = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic [7:0]      mem_addr,
  input  logic [7:0]      mem_w_data,
  input  logic            mem_w_en,
  output logic [7:0]      mem_r_data,
  input  logic            int_ret,
  output logic            int_req,
  output logic [7:0]      int_vec,
  output logic [7:0]      int_en
);

  state_e          state_q, state_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [7:0]      enable_q, enable_d;
  logic [7:0]      vec_q [NSRC];
  logic [7:0]      vec_d [NSRC];
  logic [1:0]      cur_id_q, cur_id_d;
  logic            issued_q, issued_d;
  logic [1:0]      win_id;
  logic            issue;
  logic [7:0]      offset;
  logic            in_win;
  logic            wr;

  intc_edge_detect #(.W(NSRC)) u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sig_i   (irq_src),
    .rise_o  (rise)
  );

  // Unsigned wrap makes any address below BASE_ADDR fall outside the window too.
  assign offset = mem_addr - BASE_ADDR;
  assign in_win = (offset < 8'd8);
  assign wr     = mem_w_en & in_win;
  assign elig   = pend_q & enable_q[4 +: NSRC];

  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = i[1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_q[0] && (|elig)) begin
          state_d = ST_ISSUE;
          issue   = 1'b1;
        end
      end
      ST_ISSUE:   state_d = ST_SERVICE;
      ST_SERVICE: if (int_ret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    vec_d    = vec_q;
    clr      = '0;
    cur_id_d = cur_id_q;
    issued_d = issued_q;
    if (wr) begin
      case (offset[2:0])
        OFF_ENABLE:  enable_d = mem_w_data;
        OFF_PENDING: clr      = mem_w_data[NSRC-1:0];
        OFF_STATUS, OFF_RSVD: ;
        default:     vec_d[offset[1:0]] = mem_w_data;
      endcase
    end
    if (issue) begin
      cur_id_d    = win_id;
      issued_d    = 1'b1;
      clr[win_id] = 1'b1;
    end
    // A new edge outranks any clear of the same bit in this cycle.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      enable_q <= '0;
      cur_id_q <= '0;
      issued_q <= 1'b0;
      for (int i = 0; i < NSRC; i++) vec_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      enable_q <= enable_d;
      cur_id_q <= cur_id_d;
      issued_q <= issued_d;
      vec_q    <= vec_d;
    end
  end

  assign int_req = (state_q == ST_ISSUE);
  assign int_vec = issued_q ? vec_q[cur_id_q] : 8'h00;
  assign int_en  = enable_q;

  always_comb begin
    mem_r_data = 8'h00;
    if (in_win) begin
      case (offset[2:0])
        OFF_ENABLE:  mem_r_data = enable_q;
        OFF_PENDING: mem_r_data = 8'(pend_q);
        OFF_STATUS:  mem_r_data = {state_q != ST_IDLE, 5'b0, cur_id_q};
        OFF_RSVD:    mem_r_data = 8'h00;
        default:     mem_r_data = vec_q[offset[1:0]];
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Cycle-table bench for interrupt_controller with an expected-result queue, plus a reset-during-service sequence.
module tb_interrupt_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] irq_src;
  logic [7:0] mem_addr;
  logic [7:0] mem_w_data;
  logic       mem_w_en;
  logic [7:0] mem_r_data;
  logic       int_ret;
  logic       int_req;
  logic [7:0] int_vec;
  logic [7:0] int_en;

  always #5 clock = ~clock;

  interrupt_controller #(.BASE_ADDR(8'hF0), .NSRC(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_w_en   (mem_w_en),
    .mem_r_data (mem_r_data),
    .int_ret    (int_ret),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_en     (int_en)
  );

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ret;
    logic       exp_req;
    logic       chk_vec;
    logic [7:0] exp_vec;
    logic       chk_rd;
    logic [7:0] exp_rd;
  } row_t;

  row_t tbl[$];
  row_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic row_t r(input logic [3:0] irq, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic ret, input logic exp_req,
                             input logic chk_vec, input logic [7:0] exp_vec,
                             input logic chk_rd, input logic [7:0] exp_rd);
    row_t x;
    x.irq = irq; x.we = we; x.addr = addr; x.wdata = wdata; x.ret = ret;
    x.exp_req = exp_req; x.chk_vec = chk_vec; x.exp_vec = exp_vec;
    x.chk_rd = chk_rd; x.exp_rd = exp_rd;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    mem_addr = a; mem_w_data = d; mem_w_en = 1'b1;
    cycle();
    mem_w_en = 1'b0;
  endtask

  initial begin
    row_t e;
    irq_src = '0; mem_addr = 8'hF0; mem_w_data = '0; mem_w_en = 1'b0; int_ret = 1'b0;
    repeat (2) @(negedge clock);

    chk("rst int_req", {7'b0, int_req}, 8'h00);
    chk("rst int_vec", int_vec, 8'h00);
    chk("rst int_en", int_en, 8'h00);
    chk("rst ENABLE", mem_r_data, 8'h00);
    mem_addr = 8'hF4; #1;
    chk("rst VEC0", mem_r_data, 8'h00);
    mem_addr = 8'hF2; #1;
    chk("rst STATUS", mem_r_data, 8'h00);
    reset_n = 1'b1;

    // single source, latency, STATUS, address window
    tbl.push_back(r(4'h0, 1, 8'hF0, 8'h11, 0, 0, 1, 8'h00, 1, 8'h11));
    tbl.push_back(r(4'h0, 1, 8'hF4, 8'h40, 0, 0, 1, 8'h00, 1, 8'h40));
    tbl.push_back(r(4'h1, 0, 8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 1, 8'h00, 1, 8'h01));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 1, 1, 8'h40, 1, 8'h80));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 1, 8'h40, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h80));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 1, 0, 1, 8'h40, 1, 8'h00));
    tbl.push_back(r(4'h0, 1, 8'h70, 8'hFF, 0, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h11));
    tbl.push_back(r(4'h0, 0, 8'hF3, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    // simultaneous sources, priority, int_ret ignored in IDLE/ISSUE, back-to-back
    tbl.push_back(r(4'h0, 1, 8'hF0, 8'hF1, 0, 0, 0, 8'h00, 1, 8'hF1));
    tbl.push_back(r(4'h0, 1, 8'hF5, 8'h51, 0, 0, 0, 8'h00, 1, 8'h51));
    tbl.push_back(r(4'h0, 1, 8'hF7, 8'h73, 0, 0, 0, 8'h00, 1, 8'h73));
    tbl.push_back(r(4'hA, 0, 8'hF1, 8'h00, 1, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h0A));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 1, 1, 8'h51, 1, 8'h08));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 1, 0, 1, 8'h51, 1, 8'h81));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h81));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 1, 0, 1, 8'h51, 1, 8'h08));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 1, 1, 8'h73, 1, 8'h83));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 1, 8'h73, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 1, 0, 1, 8'h73, 1, 8'h03));
    // masked source stays pending, W1C, unmask releases it
    tbl.push_back(r(4'h0, 1, 8'hF0, 8'h21, 0, 0, 0, 8'h00, 1, 8'h21));
    tbl.push_back(r(4'h1, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h01));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h01));
    tbl.push_back(r(4'h0, 1, 8'hF1, 8'h01, 0, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h1, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h01));
    tbl.push_back(r(4'h0, 1, 8'hF0, 8'h11, 0, 0, 0, 8'h00, 1, 8'h11));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 1, 1, 8'h40, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h80));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 1, 0, 0, 8'h00, 1, 8'h00));
    // no nesting, set beats W1C, VEC edit and ENABLE[0] clear during service
    tbl.push_back(r(4'h0, 1, 8'hF0, 8'hF1, 0, 0, 0, 8'h00, 1, 8'hF1));
    tbl.push_back(r(4'h0, 1, 8'hF6, 8'h62, 0, 0, 0, 8'h00, 1, 8'h62));
    tbl.push_back(r(4'h1, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h01));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 1, 1, 8'h40, 1, 8'h80));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h80));
    tbl.push_back(r(4'h4, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(r(4'h0, 1, 8'hF1, 8'h04, 0, 0, 0, 8'h00, 1, 8'h04));
    tbl.push_back(r(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 8'h00, 1, 8'h04));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 0, 1, 8'h40, 1, 8'h80));
    tbl.push_back(r(4'h0, 1, 8'hF4, 8'h44, 0, 0, 1, 8'h44, 1, 8'h44));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 1, 0, 1, 8'h44, 1, 8'h00));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 1, 1, 8'h62, 1, 8'h82));
    tbl.push_back(r(4'h0, 1, 8'hF0, 8'hF0, 0, 0, 0, 8'h00, 1, 8'hF0));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h82));
    tbl.push_back(r(4'h0, 0, 8'hF2, 8'h00, 1, 0, 1, 8'h62, 1, 8'h02));

    for (int i = 0; i < tbl.size(); i++) begin
      irq_src    = tbl[i].irq;
      mem_w_en   = tbl[i].we;
      mem_addr   = tbl[i].addr;
      mem_w_data = tbl[i].wdata;
      int_ret    = tbl[i].ret;
      sb.push_back(tbl[i]);
      cycle();
      e = sb.pop_front();
      chk($sformatf("row%0d int_req", i), {7'b0, int_req}, {7'b0, e.exp_req});
      if (e.chk_vec) chk($sformatf("row%0d int_vec", i), int_vec, e.exp_vec);
      if (e.chk_rd)  chk($sformatf("row%0d rdata@%02h", i, e.addr), mem_r_data, e.exp_rd);
    end
    irq_src = '0; mem_w_en = 1'b0; int_ret = 1'b0;
    chk("int_en mirror", int_en, 8'hF0);

    // reset while in service, sources held high across release
    wr(8'hF0, 8'hF3);
    irq_src = 4'h1;
    cycle();
    irq_src = 4'h0;
    repeat (3) cycle();
    mem_addr = 8'hF2; #1;
    chk("pre-reset STATUS", mem_r_data, 8'h80);
    chk("pre-reset int_vec", int_vec, 8'h44);
    irq_src = 4'hF;
    #2 reset_n = 1'b0;
    #1;
    chk("async rst int_req", {7'b0, int_req}, 8'h00);
    chk("async rst int_vec", int_vec, 8'h00);
    chk("async rst int_en", int_en, 8'h00);
    chk("async rst STATUS", mem_r_data, 8'h00);
    mem_addr = 8'hF1; #1;
    chk("async rst PENDING", mem_r_data, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
    chk("post-rst PENDING", mem_r_data, 8'h00);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("post-rst int_req c%0d", k), {7'b0, int_req}, 8'h00);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
